// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 request-port arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Latched command encoding: bit 0 = read, bit 1 = write
    localparam logic [1:0] L2_CMD_NONE  = 2'b00;
    localparam logic [1:0] L2_CMD_READ  = 2'b01;
    localparam logic [1:0] L2_CMD_WRITE = 2'b10;

    localparam int unsigned L2_CMD_RD_BIT = 0;
    localparam int unsigned L2_CMD_WR_BIT = 1;

endpackage

// File: rtl/l2_arb_req_latch.sv
// Register bank holding the granted request (command, address, write data).
// Loaded once per grant so the L2 sees stable inputs for the whole transaction.
module l2_arb_req_latch
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [1:0]        cmd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [1:0]        cmd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LINE_W-1:0] wdata_o
);

    logic [1:0]        cmd_d,   cmd_q;
    logic [ADDR_W-1:0] addr_d,  addr_q;
    logic [LINE_W-1:0] wdata_d, wdata_q;

    // Hold the current request unless a new grant loads it
    always_comb begin
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load_i) begin
            cmd_d   = cmd_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    // Request registers with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q   <= L2_CMD_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign cmd_o   = cmd_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 request port between the L1 I-cache and D-cache miss ports.
// Optional build macro: ARB_ROUND_ROBIN_EN -- when defined, simultaneous requests
// go to the side opposite the last completed grant; otherwise the D side wins ties.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    arb_state_t state_d, state_q;
    grant_t     last_grant_d, last_grant_q;
    grant_t     tie_winner;
    grant_t     grant_sel;

    logic              i_req, d_req;
    logic              load;
    logic [1:0]        cmd_in;
    logic [ADDR_W-1:0] addr_in;
    logic [LINE_W-1:0] wdata_in;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              busy;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_winner = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
`else
    assign tie_winner = GRANT_D;
`endif

    // Next-state, grant selection and request-latch load
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_sel    = GRANT_I;
        load         = 1'b0;
        cmd_in       = L2_CMD_NONE;
        addr_in      = '0;
        wdata_in     = '0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        grant_sel = tie_winner;
                    end else if (d_req) begin
                        grant_sel = GRANT_D;
                    end else begin
                        grant_sel = GRANT_I;
                    end
                    load = 1'b1;
                    if (grant_sel == GRANT_D) begin
                        cmd_in   = d_write ? L2_CMD_WRITE : L2_CMD_READ;
                        addr_in  = d_addr;
                        wdata_in = d_wdata;
                        state_d  = D_BUSY;
                    end else begin
                        cmd_in   = L2_CMD_READ;
                        addr_in  = i_addr;
                        state_d  = I_BUSY;
                    end
                end
            end
            // Completion always returns through IDLE so a dropping requester
            // cannot be re-granted on the following edge.
            I_BUSY: begin
                if (l2_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_I;
                end
            end
            D_BUSY: begin
                if (l2_resp) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and last-grant registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    l2_arb_req_latch #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req_latch (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .cmd_i   (cmd_in),
        .addr_i  (addr_in),
        .wdata_i (wdata_in),
        .cmd_o   (cmd_q),
        .addr_o  (addr_q),
        .wdata_o (wdata_q)
    );

    // L2 command from latched copies only; responses routed to the granted side
    always_comb begin
        busy     = (state_q == I_BUSY) || (state_q == D_BUSY);
        l2_read  = busy & cmd_q[L2_CMD_RD_BIT];
        l2_write = busy & cmd_q[L2_CMD_WR_BIT];
        l2_addr  = busy ? addr_q  : '0;
        l2_wdata = busy ? wdata_q : '0;
        i_resp   = (state_q == I_BUSY) & l2_resp;
        d_resp   = (state_q == D_BUSY) & l2_resp;
        i_rdata  = (state_q == I_BUSY) ? l2_rdata : '0;
        d_rdata  = (state_q == D_BUSY) ? l2_rdata : '0;
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: vector table plus hand-written corner sequences,
// with a response scoreboard. Honours ARB_ROUND_ROBIN_EN when defined.
module tb_l2_arbiter;
    import l2_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;

    always #5 clk = ~clk;

    l2_arbiter #(
        .ADDR_W (AW),
        .LINE_W (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_resp  (l2_resp)
    );

    // side: 0 = I, 1 = D
    typedef struct {
        bit            side;
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            lat;
    } rec_t;

    typedef struct {
        bit            ir;
        bit            dr;
        bit            dw;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [LW-1:0] dwd;
        logic [LW-1:0] rd;
        int            lat;
        bit            scr;
    } vec_t;

    rec_t sbq[$];
    rec_t mon_e;
    rec_t hook_rec;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   exp_last;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic rec_t mk_i(input logic [AW-1:0] a, input logic [LW-1:0] rd, input int lat);
        rec_t r;
        r = '{1'b0, L2_CMD_READ, a, '0, rd, lat};
        return r;
    endfunction

    function automatic rec_t mk_d(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                                  input logic [LW-1:0] rd, input int lat);
        rec_t r;
        r = '{1'b1, wr ? L2_CMD_WRITE : L2_CMD_READ, a, wd, rd, lat};
        return r;
    endfunction

    // Expected winner of a simultaneous request
    function automatic bit tie_side();
`ifdef ARB_ROUND_ROBIN_EN
        return !exp_last;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard: every completion pops the oldest expected transaction
    always begin
        @(negedge clk);
        #2;
        if (rst && (i_resp || d_resp)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_resp", {i_resp, d_resp}, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_i_resp", i_resp, !mon_e.side);
                chk("sb_d_resp", d_resp, mon_e.side);
                chk("sb_rdata", mon_e.side ? d_rdata : i_rdata, mon_e.rdata);
                chk("sb_addr", l2_addr, mon_e.addr);
                chk("sb_cmd", {l2_write, l2_read}, mon_e.cmd);
                chk("sb_wdata", l2_wdata, mon_e.wdata);
            end
        end
    end

    // Entered on the negedge where the request is visible in IDLE.
    // hook 1: raise a pending D request; hook 2: re-raise an I request.
    task automatic serve(input rec_t r, input bit scr, input int hook);
        l2_rdata = rnd_line();
        @(negedge clk);
        #1;
        chk("cmd_first", {l2_write, l2_read}, r.cmd);
        chk("addr_first", l2_addr, r.addr);
        chk("wdata_first", l2_wdata, r.wdata);
        chk("no_early_resp", {i_resp, d_resp}, 0);
        chk("other_rdata_zero", r.side ? i_rdata : d_rdata, 0);
        if (scr) begin
            if (r.side) begin
                d_addr  = ~d_addr;
                d_wdata = ~d_wdata;
            end else begin
                i_addr = ~i_addr;
            end
        end
        if (hook == 1) begin
            d_read  = 1'b1;
            d_write = 1'b0;
            d_addr  = hook_rec.addr;
            d_wdata = hook_rec.wdata;
            sbq.push_back(hook_rec);
        end else if (hook == 2) begin
            i_read = 1'b1;
            i_addr = hook_rec.addr;
            sbq.push_back(hook_rec);
        end
        for (int k = 1; k < r.lat; k++) begin
            @(negedge clk);
            l2_rdata = rnd_line();
            #1;
            chk("cmd_held", {l2_write, l2_read}, r.cmd);
            chk("addr_held", l2_addr, r.addr);
            chk("wdata_held", l2_wdata, r.wdata);
            chk("no_resp_wait", {i_resp, d_resp}, 0);
        end
        @(negedge clk);
        l2_resp  = 1'b1;
        l2_rdata = r.rdata;
        #1;
        chk("resp_granted", r.side ? d_resp : i_resp, 1);
        chk("resp_other", r.side ? i_resp : d_resp, 0);
        @(negedge clk);
        l2_resp = 1'b0;
        if (r.side) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        exp_last = r.side;
        #1;
        chk("idle_no_cmd", {l2_write, l2_read}, 0);
        chk("idle_no_resp", {i_resp, d_resp}, 0);
    endtask

    vec_t vecs[6];
    rec_t ri, rd, rh1, rh2;
    bit   want_i, want_d, first_d;

    initial begin
        vecs[0] = '{1, 0, 0, 32'h0000_1040, 32'h0, '0, {32{8'hA5}}, 5, 1};
        vecs[1] = '{0, 0, 1, 32'h0, 32'h8000_0000, {8{32'h1234_5678}}, {8{32'h0BAD_F00D}}, 3, 1};
        vecs[2] = '{0, 1, 0, 32'h0, 32'h0000_0300, {8{32'hCAFE_0300}}, {8{32'h3333_0300}}, 1, 0};
        vecs[3] = '{1, 1, 0, 32'h0000_0100, 32'h0000_0200, {8{32'h0000_0200}},
                    {8{32'h1111_2222}}, 2, 0};
        vecs[4] = '{1, 0, 1, 32'h0000_0140, 32'h0000_0240, {8{32'hDEAD_0240}},
                    {8{32'h4444_5555}}, 4, 0};
        vecs[5] = '{1, 1, 0, 32'h0000_0180, 32'h0000_0280, {8{32'hBEEF_0280}},
                    {8{32'h6666_7777}}, 2, 1};

        // Reset with activity on the inputs: everything must stay quiet
        rst      = 1'b0;
        i_read   = 1'b1;
        i_addr   = 32'h1234;
        d_read   = 1'b0;
        d_write  = 1'b1;
        d_addr   = 32'h5678;
        d_wdata  = rnd_line();
        l2_resp  = 1'b1;
        l2_rdata = rnd_line();
        exp_last = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_l2_addr", l2_addr, 0);
        chk("rst_l2_wdata", l2_wdata, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk);
        i_read  = 1'b0;
        d_write = 1'b0;
        l2_resp = 1'b0;
        rst     = 1'b1;

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            i_read  = vecs[v].ir;
            d_read  = vecs[v].dr;
            d_write = vecs[v].dw;
            i_addr  = vecs[v].ir ? vecs[v].ia : AW'($urandom);
            d_addr  = (vecs[v].dr || vecs[v].dw) ? vecs[v].da : AW'($urandom);
            d_wdata = vecs[v].dwd;
            ri      = mk_i(vecs[v].ia, vecs[v].rd, vecs[v].lat);
            rd      = mk_d(vecs[v].dw, vecs[v].da, vecs[v].dwd, ~vecs[v].rd, vecs[v].lat);
            want_i  = vecs[v].ir;
            want_d  = vecs[v].dr | vecs[v].dw;
            first_d = (want_i && want_d) ? tie_side() : want_d;
            if (first_d) begin
                sbq.push_back(rd);
                if (want_i) sbq.push_back(ri);
                serve(rd, vecs[v].scr, 0);
                if (want_i) serve(ri, 1'b0, 0);
            end else begin
                sbq.push_back(ri);
                if (want_d) sbq.push_back(rd);
                serve(ri, vecs[v].scr, 0);
                if (want_d) serve(rd, 1'b0, 0);
            end
        end

        // I in flight, D raised mid-transaction, I re-raised while D runs
        rh1 = mk_d(1'b0, 32'h0000_0600, {8{32'hAAAA_0600}}, {8{32'hD00D_0600}}, 2);
        rh2 = mk_i(32'h0000_0540, {8{32'h1E1E_0540}}, 3);
        @(negedge clk);
        i_read = 1'b1;
        i_addr = 32'h0000_0500;
        ri     = mk_i(32'h0000_0500, {8{32'h5555_0500}}, 2);
        sbq.push_back(ri);
        hook_rec = rh1;
        serve(ri, 1'b0, 1);
        hook_rec = rh2;
        serve(rh1, 1'b0, 2);
        serve(rh2, 1'b0, 0);

        // Spurious L2 response while IDLE
        @(negedge clk);
        l2_resp  = 1'b1;
        l2_rdata = rnd_line();
        #1;
        chk("spur_resp", {i_resp, d_resp}, 0);
        chk("spur_cmd", {l2_write, l2_read}, 0);
        chk("spur_i_rdata", i_rdata, 0);
        @(negedge clk);
        l2_resp = 1'b0;
        #1;
        chk("spur_after_cmd", {l2_write, l2_read}, 0);

        // Reset in the third D_BUSY cycle
        @(negedge clk);
        d_write = 1'b1;
        d_addr  = 32'h9000_0000;
        d_wdata = {8{32'h7777_9000}};
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_write", l2_write, 1);
        chk("pre_rst_addr", l2_addr, 32'h9000_0000);
        l2_resp = 1'b1;
        rst     = 1'b0;
        #1;
        chk("midrst_write", l2_write, 0);
        chk("midrst_read", l2_read, 0);
        chk("midrst_addr", l2_addr, 0);
        chk("midrst_wdata", l2_wdata, 0);
        chk("midrst_resp", {i_resp, d_resp}, 0);
        chk("midrst_d_rdata", d_rdata, 0);
        @(negedge clk);
        d_write  = 1'b0;
        l2_resp  = 1'b0;
        rst      = 1'b1;
        exp_last = 1'b0;
        #1;
        chk("postrst_idle", {l2_write, l2_read}, 0);
        @(negedge clk);
        i_read = 1'b1;
        i_addr = 32'h0000_0700;
        ri     = mk_i(32'h0000_0700, {8{32'h0700_0700}}, 2);
        sbq.push_back(ri);
        serve(ri, 1'b0, 0);

        // Tie after the I completion following reset
        @(negedge clk);
        i_read  = 1'b1;
        i_addr  = 32'h0000_0800;
        d_read  = 1'b1;
        d_addr  = 32'h0000_0900;
        d_wdata = {8{32'h0900_0900}};
        ri      = mk_i(32'h0000_0800, {8{32'h0800_AAAA}}, 1);
        rd      = mk_d(1'b0, 32'h0000_0900, {8{32'h0900_0900}}, {8{32'h0900_BBBB}}, 1);
        if (tie_side()) begin
            sbq.push_back(rd);
            sbq.push_back(ri);
            serve(rd, 1'b0, 0);
            serve(ri, 1'b0, 0);
        end else begin
            sbq.push_back(ri);
            sbq.push_back(rd);
            serve(ri, 1'b0, 0);
            serve(rd, 1'b0, 0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-port arbiter that shares the single L2 cache request port between the L1 instruction-cache miss port (read-only) and the L1 data-cache miss port (read/write).
- Sits between the two L1 cache controllers and the L2 cache.
- Registers the granted request (address, write data, command) so L2 inputs are stable for the whole transaction.
- Routes the L2 response and read data back to the granted requester only.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache-line width in bits

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset
i_read  in  1  I-side line read request
i_addr  in  ADDR_W  I-side line address
i_rdata  out  LINE_W  I-side read data
i_resp  out  1  I-side completion
d_read  in  1  D-side line read request
d_write  in  1  D-side line write-back request
d_addr  in  ADDR_W  D-side line address
d_wdata  in  LINE_W  D-side write data
d_rdata  out  LINE_W  D-side read data
d_resp  out  1  D-side completion
l2_read  out  1  read command to L2
l2_write  out  1  write command to L2
l2_addr  out  ADDR_W  address to L2
l2_wdata  out  LINE_W  write data to L2
l2_rdata  in  LINE_W  read data from L2
l2_resp  in  1  L2 completion

Behaviour:
- States: IDLE, I_BUSY, D_BUSY. Held in the shared enum arb_state_t.
- Reset value (rst low, asynchronous): state=IDLE, latched cmd/addr/wdata=0, last_grant=I. All outputs 0.
- IDLE:
  - Samples requests. A D request is d_read|d_write; d_read and d_write are never asserted together, and the block's behaviour is undefined if they are.
  - Only I requesting -> latch i_addr and read cmd, go to I_BUSY.
  - Only D requesting -> latch d_addr, d_wdata and d_read/d_write, go to D_BUSY.
  - Both requesting -> priority per the optional feature.
  - No L2 command is driven in IDLE.
- I_BUSY / D_BUSY:
  - l2_read, l2_write, l2_addr and l2_wdata are driven from the latched registers only.
  - Latency: first L2 command cycle is one cycle after the request is seen in IDLE.
  - Commands are held constant until l2_resp.
  - In the l2_resp cycle, the granted side's resp is l2_resp combinationally and its rdata is l2_rdata. The other side's resp is 0.
  - Next state is IDLE and last_grant updates at that edge.
- i_rdata and d_rdata are 0 whenever that side is not granted.
- A requester must drop its request in the cycle after its resp. The IDLE cycle after completion is mandatory (no back-to-back grant without IDLE), which guarantees that a dropping requester is never re-granted.
- A non-granted requester stays pending untouched. Its inputs may change; they are sampled only in IDLE.
- Changes to granted-side inputs during a transaction are ignored, because the latched copies are used.
- l2_resp in IDLE is ignored: no resp is forwarded and the state is unchanged.
- Reset mid-transaction: immediate return to IDLE and outputs go to 0. The L2 transaction is abandoned; the L2 is reset by the same signal.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests in IDLE, grant the side opposite last_grant. last_grant updates at each transaction completion.
- Undefined: fixed priority, D-side always wins ties. last_grant is still maintained but unused.

Decomposition:
- Package l2_arb_pkg holds:
  - arb_state_t: IDLE, I_BUSY, D_BUSY
  - grant_t: GRANT_I, GRANT_D
  - L2_CMD_NONE/READ/WRITE localparams
- One natural sub-module, l2_arb_req_latch: the clocked command/address/wdata register bank with load-enable and async clear.
- Grant and state logic stay in l2_arbiter.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000_1040; L2 responds after 5 cycles with rdata=0xA5..A5 -> l2_read=1 and l2_addr=0x1040 from the cycle after the request; i_resp=1 with i_rdata=0xA5..A5 in the resp cycle; d_resp stays 0.
- D write-back: d_write=1, d_addr=0x8000_0000, d_wdata=0x1234..; the bench changes d_wdata mid-transaction -> l2_wdata holds the original value; l2_write=1 until l2_resp; d_resp pulses for 1 cycle.
- Simultaneous i_read and d_read at addresses 0x100 and 0x200, each serviced to completion:
  - Without the macro: D is served first, then IDLE, then I.
  - With ARB_ROUND_ROBIN_EN and last_grant=D: I is served first.
- Back-to-back I requests with D held pending (round-robin build) -> D is granted after the first I completion; I does not win twice in a row.
- Reset asserted low in the 3rd cycle of D_BUSY -> all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE; a new i_read is granted normally.
- Spurious l2_resp in IDLE -> no i_resp or d_resp; state stays IDLE.
